// File: rtl/lut_sweep_engine.sv
// Programmable truth-table evaluator: N_FN functions of N_IN inputs with
// registered direct evaluation and a valid/ready sweep that counts minterms.
module lut_sweep_engine #(
    parameter int unsigned N_IN = 4,
    parameter int unsigned N_FN = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [3:0]                  cfg_fn,
    input  logic [(1 << N_IN)-1:0]      cfg_tt,
    input  logic [N_IN-1:0]             ev_in,
    output logic [N_FN-1:0]             ev_out,
    input  logic                        start,
    output logic                        busy,
    output logic                        row_valid,
    input  logic                        row_ready,
    output logic [N_IN-1:0]             row_idx,
    output logic [N_FN-1:0]             row_val,
    output logic                        done,
    output logic [N_FN*(N_IN+1)-1:0]    count
);

    localparam int unsigned TT_W = 1 << N_IN;
    localparam int unsigned CW   = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state;
    logic [TT_W-1:0]     tt [N_FN];
    logic [N_IN-1:0]     idx;
    logic [N_IN-1:0]     idx_nxt;
    logic [N_FN-1:0]     col_first;
    logic [N_FN-1:0]     col_nxt;
    logic [N_FN-1:0]     col_ev;
    logic [CW-1:0]       cnt [N_FN];

    // Column reads of the table set: first row, next row and direct-eval row.
    always_comb begin
        idx_nxt   = idx + N_IN'(1);
        col_first = '0;
        col_nxt   = '0;
        col_ev    = '0;
        for (int j = 0; j < N_FN; j++) begin
            col_first[j] = tt[j][0];
            col_nxt[j]   = tt[j][idx_nxt];
            col_ev[j]    = tt[j][ev_in];
        end
    end

    // Tables are frozen during RUN so a sweep sees one consistent set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_FN; j++) begin
                tt[j] <= '0;
            end
        end else if (cfg_we && (state != S_RUN)) begin
            for (int j = 0; j < N_FN; j++) begin
                if (cfg_fn == 4'(j)) begin
                    tt[j] <= cfg_tt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_out <= '0;
        end else begin
            ev_out <= col_ev;
        end
    end

    // Sweep controller; row_val is preloaded so it always matches row_idx.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            row_valid <= 1'b0;
            row_val   <= '0;
            done      <= 1'b0;
            for (int j = 0; j < N_FN; j++) begin
                cnt[j] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= S_RUN;
                        idx       <= '0;
                        busy      <= 1'b1;
                        row_valid <= 1'b1;
                        row_val   <= col_first;
                        for (int j = 0; j < N_FN; j++) begin
                            cnt[j] <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (row_ready) begin
                        for (int j = 0; j < N_FN; j++) begin
                            cnt[j] <= cnt[j] + CW'(row_val[j]);
                        end
                        if (idx == LAST_IDX) begin
                            state     <= S_DONE;
                            row_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx     <= idx_nxt;
                            row_val <= col_nxt;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign row_idx = idx;

    for (genvar g = 0; g < N_FN; g++) begin : g_count
        assign count[g*CW +: CW] = cnt[g];
    end

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Scoreboard bench for lut_sweep_engine: sweep rows, counts, backpressure,
// direct evaluation, ignored requests and mid-sweep reset.
module tb_lut_sweep_engine;

    localparam int unsigned N_IN = 4;
    localparam int unsigned N_FN = 3;
    localparam int unsigned TT_W = 1 << N_IN;
    localparam int unsigned CW   = N_IN + 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cfg_we = 1'b0;
    logic [3:0]             cfg_fn = '0;
    logic [TT_W-1:0]        cfg_tt = '0;
    logic [N_IN-1:0]        ev_in = '0;
    logic [N_FN-1:0]        ev_out;
    logic                   start = 1'b0;
    logic                   busy;
    logic                   row_valid;
    logic                   row_ready = 1'b0;
    logic [N_IN-1:0]        row_idx;
    logic [N_FN-1:0]        row_val;
    logic                   done;
    logic [N_FN*CW-1:0]     count;

    int checks   = 0;
    int failures = 0;

    logic [TT_W-1:0] m_tt [N_FN];
    logic [N_IN-1:0] idx_q [$];
    logic [N_FN-1:0] val_q [$];

    lut_sweep_engine #(.N_IN(N_IN), .N_FN(N_FN)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_fn(cfg_fn),
        .cfg_tt(cfg_tt), .ev_in(ev_in), .ev_out(ev_out), .start(start),
        .busy(busy), .row_valid(row_valid), .row_ready(row_ready),
        .row_idx(row_idx), .row_val(row_val), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_FN-1:0] model_row(input int i);
        logic [N_FN-1:0] r;
        for (int j = 0; j < N_FN; j++) r[j] = m_tt[j][i];
        return r;
    endfunction

    task automatic load_fn(input int fn, input logic [TT_W-1:0] val);
        cfg_we = 1'b1;
        cfg_fn = 4'(fn);
        cfg_tt = val;
        tick();
        cfg_we = 1'b0;
        if (fn < N_FN) m_tt[fn] = val;
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (ev_out !== '0 || busy !== 1'b0 || row_valid !== 1'b0 || row_idx !== '0 ||
            row_val !== '0 || done !== 1'b0 || count !== '0) begin
            failures++;
            $display("FAIL %s: ev_out=%0h busy=%0b row_valid=%0b row_idx=%0h row_val=%0h done=%0b count=%0h, all required 0",
                     name, ev_out, busy, row_valid, row_idx, row_val, done, count);
        end
    endtask

    task automatic check_counts(input string name);
        for (int j = 0; j < N_FN; j++) begin
            checks++;
            if (count[j*CW +: CW] !== CW'($countones(m_tt[j]))) begin
                failures++;
                $display("FAIL %s count%0d: got %0d required %0d", name, j,
                         count[j*CW +: CW], $countones(m_tt[j]));
            end
        end
    endtask

    task automatic check_ev_all(input string name);
        for (int i = 0; i < TT_W; i++) begin
            ev_in = N_IN'(i);
            tick();
            checks++;
            if (ev_out !== model_row(i)) begin
                failures++;
                $display("FAIL %s ev_in=%0d: got %0h required %0h", name, i, ev_out, model_row(i));
            end
        end
    endtask

    // Runs one full sweep, comparing each accepted row against the scoreboard.
    task automatic run_sweep(input string name, input bit bp, input bit inject);
        logic [N_IN-1:0] p_idx;
        logic [N_FN-1:0] p_val;
        logic [N_IN-1:0] e_idx;
        logic [N_FN-1:0] e_val;
        bit prev_stall = 1'b0;
        bit stretched = 1'b0;
        bit injected = 1'b0;
        bit finished = 1'b0;
        int stall_left = 0;
        int cyc;
        int done_cnt = 0;
        int done_cyc = -1;
        p_idx = '0;
        p_val = '0;
        for (int i = 0; i < TT_W; i++) begin
            idx_q.push_back(N_IN'(i));
            val_q.push_back(model_row(i));
        end
        row_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        checks++;
        if (busy !== 1'b1 || row_valid !== 1'b1 || row_idx !== '0) begin
            failures++;
            $display("FAIL %s start: busy=%0b row_valid=%0b row_idx=%0d, required 1 1 0",
                     name, busy, row_valid, row_idx);
        end
        while (!finished && cyc < 300) begin
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                finished = 1'b1;
                checks++;
                if (busy !== 1'b0 || row_valid !== 1'b0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL %s after_done: busy=%0b row_valid=%0b done=%0b, required 0 0 0",
                             name, busy, row_valid, done);
                end
            end else begin
                if (done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                    checks++;
                    if (row_valid !== 1'b0 || busy !== 1'b1) begin
                        failures++;
                        $display("FAIL %s done_cycle: row_valid=%0b busy=%0b, required 0 1",
                                 name, row_valid, busy);
                    end
                end
                if (prev_stall) begin
                    checks++;
                    if (row_valid !== 1'b1 || row_idx !== p_idx || row_val !== p_val) begin
                        failures++;
                        $display("FAIL %s stall_hold: idx=%0d val=%0h valid=%0b, required idx=%0d val=%0h valid=1",
                                 name, row_idx, row_val, row_valid, p_idx, p_val);
                    end
                end
                if (bp && !stretched && row_valid === 1'b1 && row_idx == 7) begin
                    stall_left = 5;
                    stretched = 1'b1;
                end
                if (!bp) row_ready = 1'b1;
                else if (stall_left > 0) begin
                    row_ready = 1'b0;
                    stall_left--;
                end else row_ready = ($urandom_range(0, 2) != 0);
                if (inject && !injected && row_valid === 1'b1 && row_idx == 5) begin
                    cfg_we = 1'b1;
                    cfg_fn = 4'd0;
                    cfg_tt = '1;
                    start = 1'b1;
                    injected = 1'b1;
                end
                if (row_valid === 1'b1 && row_ready) begin
                    checks++;
                    if (idx_q.size() == 0) begin
                        failures++;
                        $display("FAIL %s extra_row: got idx=%0d, required no more rows", name, row_idx);
                    end else begin
                        e_idx = idx_q.pop_front();
                        e_val = val_q.pop_front();
                        if (row_idx !== e_idx || row_val !== e_val) begin
                            failures++;
                            $display("FAIL %s row: got idx=%0d val=%0h required idx=%0d val=%0h",
                                     name, row_idx, row_val, e_idx, e_val);
                        end
                    end
                end
                prev_stall = (row_valid === 1'b1) && !row_ready;
                p_idx = row_idx;
                p_val = row_val;
                tick();
                cfg_we = 1'b0;
                start = 1'b0;
                cyc++;
            end
        end
        row_ready = 1'b0;
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s timeout: sweep not finished after %0d cycles, required finish", name, cyc);
        end
        checks++;
        if (done_cnt != 1 || idx_q.size() != 0) begin
            failures++;
            $display("FAIL %s done_pulses=%0d rows_left=%0d, required 1 and 0", name, done_cnt, idx_q.size());
        end
        if (!bp) begin
            checks++;
            if (done_cyc != TT_W + 1) begin
                failures++;
                $display("FAIL %s done_latency: got T+%0d required T+%0d", name, done_cyc, TT_W + 1);
            end
        end
        check_counts(name);
        idx_q.delete();
        val_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int j = 0; j < N_FN; j++) m_tt[j] = '0;
        tick();
        tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();
        check_outputs_zero("reset_release");
    endtask

    task automatic test_default_sweep();
        run_sweep("default_sweep", 1'b0, 1'b0);
    endtask

    task automatic load_ref_tables();
        load_fn(0, 16'h8888);
        load_fn(1, 16'h111F);
        load_fn(2, 16'h212E);
    endtask

    task automatic test_load_sweep();
        load_ref_tables();
        check_ev_all("ev_after_load");
        run_sweep("load_sweep", 1'b0, 1'b0);
        checks++;
        if (count !== {CW'(6), CW'(7), CW'(4)}) begin
            failures++;
            $display("FAIL load_sweep_counts: got %0h required %0h", count, {CW'(6), CW'(7), CW'(4)});
        end
    endtask

    task automatic test_backpressure();
        run_sweep("backpressure", 1'b1, 1'b0);
    endtask

    task automatic test_direct_eval();
        ev_in = 4'd3;
        cfg_we = 1'b1;
        cfg_fn = 4'd0;
        cfg_tt = '0;
        tick();
        cfg_we = 1'b0;
        checks++;
        if (ev_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL ev_collision_old: got %0b required 1", ev_out[0]);
        end
        tick();
        checks++;
        if (ev_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL ev_collision_new: got %0b required 0", ev_out[0]);
        end
        load_fn(0, 16'h8888);
        check_ev_all("ev_reload");
    endtask

    task automatic test_ignored();
        run_sweep("ignored_in_run", 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || row_valid !== 1'b0) begin
                failures++;
                $display("FAIL no_second_sweep: busy=%0b row_valid=%0b, required 0 0", busy, row_valid);
            end
        end
        check_ev_all("ev_after_run_write");
        load_fn(5, 16'hFFFF);
        check_ev_all("ev_after_bad_fn");
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        row_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (row_valid === 1'b1 && row_idx == 9) hit = 1'b1;
            else tick();
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL reset_mid_reach: idx 9 not seen, required idx 9");
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        row_ready = 1'b0;
        ev_in = '0;
        for (int j = 0; j < N_FN; j++) m_tt[j] = '0;
        check_outputs_zero("reset_mid");
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_no_done: done=%0b busy=%0b, required 0 0", done, busy);
            end
        end
        check_ev_all("reset_mid_tables");
    endtask

    initial begin
        test_reset();
        test_default_sweep();
        test_load_sweep();
        test_backpressure();
        test_direct_eval();
        test_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lut_sweep_engine.md
# lut_sweep_engine

Parametrised, programmable boolean-function evaluator: holds N_FN truth tables of N_IN inputs each. It supports direct registered evaluation and an autonomous sweep mode. Sweep mode streams every input combination 0..2^N_IN-1 with all function outputs over a valid/ready interface, and accumulates a per-function minterm count. It replaces fixed, hand-wired function blocks in the lab design and drives the same row-by-row truth-table reporting used by the benches.

## Interface
- N_IN, default 4: inputs per function; legal 1..8.
- N_FN, default 3: number of functions; legal 1..16.
- CW = N_IN+1 (derived): minterm-count width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: one clock; synchronous, active-low.
- cfg_we  in  1  truth-table write strobe.
- cfg_fn  in  4  function index; writes with cfg_fn >= N_FN are ignored.
- cfg_tt  in  2^N_IN  truth table; bit k = output for input value k.
- ev_in  in  N_IN  direct-evaluation input.
- ev_out  out  N_FN  registered direct-evaluation result; bit j = function j.
- start  in  1  sweep request, sampled in IDLE only.
- busy  out  1  high in RUN and DONE.
- row_valid  out  1  sweep row available.
- row_ready  in  1  consumer accepts row.
- row_idx  out  N_IN  input combination of current row.
- row_val  out  N_FN  function outputs for row_idx.
- done  out  1  one-cycle pulse after last row accepted.
- count  out  N_FN*CW  minterm counts; field j = bits [j*CW +: CW].

## Operation
- Storage: N_FN registers of 2^N_IN bits each. Reset clears all tables to 0.
- Table writes:
  - A write with cfg_we=1 in IDLE or DONE replaces table cfg_fn whole at the clock edge.
  - cfg_we is ignored in RUN, so a sweep reads one consistent table set.
- Direct evaluation:
  - Every cycle, ev_out <= {tt[j][ev_in]} for all j. This holds in every state.
  - A same-cycle write is not visible; ev_out uses the pre-write table.
- FSM:
  - IDLE: start=1 moves to RUN, sets idx=0, clears all counts, asserts row_valid.
  - RUN: row_valid=1, row_idx=idx, row_val[j]=tt[j][idx].
    - On an edge with row_valid&row_ready, count[j] += row_val[j].
    - If idx == 2^N_IN-1, go to DONE. Otherwise idx+1.
    - If row_ready=0, row_idx and row_val hold stable and nothing advances.
  - DONE: done=1 and row_valid=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- start in RUN or DONE is ignored; no queuing.
- Counts:
  - count holds its final values from DONE until the next accepted start.
  - Maximum value per field is 2^N_IN, so it never overflows CW.
- Reset mid-sweep: rst_n=0 at any edge gives IDLE, clears tables and counts, and abandons the sweep with no done pulse.

## Timing
- Reset values: ev_out=0, busy=0, row_valid=0, row_idx=0, row_val=0, done=0, count=0.
- start sampled high at edge T (IDLE): busy=1 and row_valid=1 with row_idx=0 from T+1.
- Throughput: one row per cycle with row_ready held high; no bubbles.
- Sweep with row_ready constantly high: 2^N_IN row cycles, then 1 DONE cycle.
  - Default parameters: 16 row cycles, done at cycle T+17, busy low from T+18.
- ev_out latency: exactly 1 cycle from ev_in.
- A table write takes effect for evaluation starting the cycle after the write edge.
- row_val for a row reflects the tables as of sweep start.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path except row_val/row_idx, which come from state only.

## Test plan
- Reset/default: release rst_n, sweep with row_ready=1 -> 16 rows, all row_val=0, counts all 0, done at T+17.
- Load and sweep (N_IN=4, N_FN=3): load fn0=16'h8888, fn1=16'h111F, fn2=16'h212E, sweep -> rows match the table bits; counts 4, 7, 6; exactly one done pulse.
- Backpressure: same tables, row_ready toggled pseudo-randomly with a 5-cycle low stretch at idx 7 -> row_idx and row_val stable while stalled, no skipped or duplicated idx, counts still 4, 7, 6.
- Direct evaluation with write collision: fn0=16'h8888 loaded, ev_in=3 while writing fn0=16'h0000 in the same cycle -> ev_out[0]=1 next cycle, 0 the cycle after.
- Ignored requests: cfg_we fn0=16'hFFFF and start=1 during RUN -> sweep unaffected, count0 stays 4, no second sweep; cfg_fn=5 write in IDLE -> no table changes.
- Reset mid-sweep: rst_n low at idx 9 -> next cycle all outputs 0, state IDLE, tables 0, no done pulse.
